// File: rtl/jk_bank_pkg.sv
// Shared types for the JK bank command sequencer: command opcodes and FSM states.
package jk_bank_pkg;

    typedef enum logic [2:0] {
        OP_HOLD     = 3'd0,
        OP_CLEAR    = 3'd1,
        OP_SET      = 3'd2,
        OP_TOGGLE   = 3'd3,
        OP_COUNT_UP = 3'd4,
        OP_SHIFT_L  = 3'd5
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Codes 6 and 7 are reserved; they run as HOLD but flag an error.
    function automatic logic is_reserved(input logic [2:0] op);
        return (op > 3'd5);
    endfunction

endpackage

// File: rtl/jk_op_decode.sv
// Combinational translation of (op, mask, bank state) into J/K drive for the bank.
module jk_op_decode
    import jk_bank_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             enable,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] mask,
    input  logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k
);

    logic [WIDTH-1:0] shifted;
    logic             carry;

    assign shifted = {q[WIDTH-2:0], 1'b0};

    // The count carry only ripples through masked bits, so a partial mask
    // forms a counter out of just those flops.
    always_comb begin
        j     = '0;
        k     = '0;
        carry = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            if (enable && mask[i]) begin
                case (op)
                    OP_CLEAR: begin
                        k[i] = 1'b1;
                    end
                    OP_SET: begin
                        j[i] = 1'b1;
                    end
                    OP_TOGGLE: begin
                        j[i] = 1'b1;
                        k[i] = 1'b1;
                    end
                    OP_COUNT_UP: begin
                        j[i] = carry;
                        k[i] = carry;
                    end
                    OP_SHIFT_L: begin
                        j[i] = shifted[i];
                        k[i] = ~shifted[i];
                    end
                    default: begin
                        j[i] = 1'b0;
                        k[i] = 1'b0;
                    end
                endcase
                carry = carry & q[i];
            end
        end
    end

endmodule

// File: rtl/jk_bank_seq_ctrl.sv
// Command sequencer driving a bank of external JK flops; optional abort input
// is enabled by defining JK_BANK_SEQ_ABORT_EN.
module jk_bank_seq_ctrl
    import jk_bank_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int REP_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_mask,
    input  logic [REP_W-1:0] cmd_rep,
    input  logic [WIDTH-1:0] q_in,
    output logic [WIDTH-1:0] j_out,
    output logic [WIDTH-1:0] k_out,
    output logic             busy,
    output logic             done,
    output logic             err
`ifdef JK_BANK_SEQ_ABORT_EN
    ,
    input  logic             abort,
    output logic             aborted
`endif
);

    state_t           state;
    logic [2:0]       op;
    logic [WIDTH-1:0] mask;
    logic [REP_W-1:0] remain;
    logic             abort_hit;
    logic             drive_en;

`ifdef JK_BANK_SEQ_ABORT_EN
    assign abort_hit = abort && (state == ST_EXEC);
`else
    assign abort_hit = 1'b0;
`endif

    // An aborting EXEC cycle must leave the bank untouched on its edge.
    assign drive_en = (state == ST_EXEC) && !abort_hit;

    jk_op_decode #(
        .WIDTH(WIDTH)
    ) u_decode (
        .enable(drive_en),
        .op    (op),
        .mask  (mask),
        .q     (q_in),
        .j     (j_out),
        .k     (k_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            op        <= OP_HOLD;
            mask      <= '0;
            remain    <= '0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
`ifdef JK_BANK_SEQ_ABORT_EN
            aborted   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef JK_BANK_SEQ_ABORT_EN
            aborted <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        state     <= ST_EXEC;
                        op        <= cmd_op;
                        mask      <= cmd_mask;
                        remain    <= cmd_rep;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (is_reserved(cmd_op)) begin
                            err <= 1'b1;
                        end
                    end
                end
                ST_EXEC: begin
                    if (abort_hit) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
`ifdef JK_BANK_SEQ_ABORT_EN
                        aborted <= 1'b1;
`endif
                    end else if (remain == '0) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else begin
                        remain <= remain - 1'b1;
                    end
                end
                ST_DONE: begin
                    state     <= ST_IDLE;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
                default: begin
                    state     <= ST_IDLE;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
